// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_I,
        GNT_D
    } grant_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    // Byte address -> word index shift.
    localparam int WORD_OFFSET_BITS = 2;

endpackage

// File: rtl/mem_arb_rsp_slot.sv
// One-entry response register with valid/ready handshake.
// A fill in the same cycle as a consume keeps the slot valid with new data.
module mem_arb_rsp_slot
    import mem_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic fill,
    input  rsp_t fill_rsp,
    input  logic rsp_ready,
    output logic rsp_valid,
    output rsp_t rsp,
    output logic free
);

    logic valid_q, valid_d;
    rsp_t rsp_q, rsp_d;

    // Next slot state: drain on consume, then let a refill win.
    always_comb begin
        valid_d = valid_q;
        rsp_d   = rsp_q;
        if (valid_q && rsp_ready) valid_d = 1'b0;
        if (fill) begin
            valid_d = 1'b1;
            rsp_d   = fill_rsp;
        end
    end

    // Slot register; reset discards any pending response.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            rsp_q   <= '0;
        end else begin
            valid_q <= valid_d;
            rsp_q   <= rsp_d;
        end
    end

    assign rsp_valid = valid_q;
    assign rsp       = rsp_q;
    // Slot can accept a new response if empty or being drained this cycle.
    assign free      = !valid_q || rsp_ready;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter for a single-ported word memory.
// D has priority; a starvation counter hands I the grant after
// STARVE_LIMIT consecutive losing cycles.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WORDS        = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req_valid,
    input  logic [31:0] i_req_addr,
    output logic        i_req_ready,
    output logic        i_rsp_valid,
    output logic [31:0] i_rsp_rdata,
    output logic        i_rsp_err,
    input  logic        i_rsp_ready,
    input  logic        d_req_valid,
    input  logic [31:0] d_req_addr,
    input  logic [31:0] d_req_wdata,
    input  logic        d_req_we,
    output logic        d_req_ready,
    output logic        d_rsp_valid,
    output logic [31:0] d_rsp_rdata,
    output logic        d_rsp_err,
    input  logic        d_rsp_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);

    localparam int NUM_PORTS = 2;  // index 0 = I, 1 = D
    localparam int CW        = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

    grant_t                 gnt;
    logic                   fault;
    logic [31:0]            sel_addr;
    rsp_t                   fill_rsp;
    logic [CW-1:0]          starve_q, starve_d;
    logic [NUM_PORTS-1:0]   slot_fill, slot_ready, slot_valid, slot_free;
    rsp_t [NUM_PORTS-1:0]   slot_rsp;
    logic                   i_elig, d_elig;

    assign slot_ready = {d_rsp_ready, i_rsp_ready};
    assign i_elig     = i_req_valid && slot_free[0];
    assign d_elig     = d_req_valid && slot_free[1];

    // Grant selection: D wins ties unless I has been starved to the limit.
    always_comb begin
        gnt = GNT_NONE;
        if (!rst) begin
            if (i_elig && (!d_elig || starve_q == LIMIT_C)) gnt = GNT_I;
            else if (d_elig)                                  gnt = GNT_D;
        end
    end

    assign i_req_ready = (gnt == GNT_I);
    assign d_req_ready = (gnt == GNT_D);
    assign slot_fill   = {d_req_ready, i_req_ready};

    // Memory port drive, fault decode and response capture data.
    always_comb begin
        sel_addr  = (gnt == GNT_I) ? i_req_addr : d_req_addr;
        fault     = (sel_addr[WORD_OFFSET_BITS-1:0] != '0) ||
                    ({{WORD_OFFSET_BITS{1'b0}}, sel_addr[31:WORD_OFFSET_BITS]} >= 32'(WORDS));
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        fill_rsp  = '0;
        if (gnt != GNT_NONE) begin
            mem_addr     = {{WORD_OFFSET_BITS{1'b0}}, sel_addr[31:WORD_OFFSET_BITS]};
            fill_rsp.err = fault;
            if (!fault && !(gnt == GNT_D && d_req_we)) fill_rsp.rdata = mem_rdata;
        end
        if (gnt == GNT_D) begin
            mem_wdata = d_req_wdata;
            mem_we    = d_req_we && !fault;
        end
    end

    // Starvation counter: counts cycles I was eligible but lost to D.
    always_comb begin
        starve_d = starve_q;
        if (!i_req_valid || gnt == GNT_I)
            starve_d = '0;
        else if (i_elig && gnt == GNT_D && starve_q != LIMIT_C)
            starve_d = starve_q + CW'(1);
    end

    // Starvation counter register.
    always_ff @(posedge clk) begin
        if (rst) starve_q <= '0;
        else     starve_q <= starve_d;
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_slot
        mem_arb_rsp_slot u_slot (
            .clk       (clk),
            .rst       (rst),
            .fill      (slot_fill[p]),
            .fill_rsp  (fill_rsp),
            .rsp_ready (slot_ready[p]),
            .rsp_valid (slot_valid[p]),
            .rsp       (slot_rsp[p]),
            .free      (slot_free[p])
        );
    end

    assign i_rsp_valid = slot_valid[0];
    assign i_rsp_rdata = slot_rsp[0].rdata;
    assign i_rsp_err   = slot_rsp[0].err;
    assign d_rsp_valid = slot_valid[1];
    assign d_rsp_rdata = slot_rsp[1].rdata;
    assign d_rsp_err   = slot_rsp[1].err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios then random traffic.
module tb_mem_arbiter;

    localparam int WORDS = 64;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req_valid, i_req_ready, i_rsp_valid, i_rsp_err, i_rsp_ready;
    logic [31:0] i_req_addr, i_rsp_rdata;
    logic        d_req_valid, d_req_we, d_req_ready, d_rsp_valid, d_rsp_err, d_rsp_ready;
    logic [31:0] d_req_addr, d_req_wdata, d_rsp_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.WORDS(WORDS), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
        .i_rsp_valid(i_rsp_valid), .i_rsp_rdata(i_rsp_rdata), .i_rsp_err(i_rsp_err),
        .i_rsp_ready(i_rsp_ready),
        .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
        .d_req_we(d_req_we), .d_req_ready(d_req_ready),
        .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata), .d_rsp_err(d_rsp_err),
        .d_rsp_ready(d_rsp_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    // Environment memory (what the DUT drives) and the bench's own reference copy.
    logic [31:0] mem     [WORDS];
    logic [31:0] ref_mem [WORDS];

    initial begin
        for (int k = 0; k < WORDS; k++) begin
            mem[k]     = (32'(k) * 32'h0101_0101) ^ 32'hA5A5_0000;
            ref_mem[k] = (32'(k) * 32'h0101_0101) ^ 32'hA5A5_0000;
        end
    end

    assign mem_rdata = (mem_addr < 32'(WORDS)) ? mem[mem_addr[5:0]] : 32'h0;

    always @(posedge clk)
        if (mem_we && mem_addr < 32'(WORDS)) mem[mem_addr[5:0]] <= mem_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t iq[$];
    exp_t dq[$];

    function automatic logic is_fault(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(WORDS));
    endfunction

    logic rst_prev = 1'b0;
    always @(posedge clk) rst_prev <= rst;

    // Reference arbitration and scoreboard push, sampled mid-cycle.
    int wait_cnt = 0;
    always @(negedge clk) begin
        logic i_el, d_el, exp_gi, exp_gd, f;
        logic [31:0] a;
        exp_t e;
        if (rst) begin
            chk("rst_i_ready", i_req_ready, 0);
            chk("rst_d_ready", d_req_ready, 0);
            chk("rst_mem_we", mem_we, 0);
            wait_cnt = 0;
        end else begin
            if (rst_prev) wait_cnt = 0;
            i_el   = i_req_valid && (!i_rsp_valid || i_rsp_ready);
            d_el   = d_req_valid && (!d_rsp_valid || d_rsp_ready);
            exp_gi = i_el && (!d_el || wait_cnt == LIMIT);
            exp_gd = d_el && !exp_gi;
            chk("i_ready", i_req_ready, exp_gi);
            chk("d_ready", d_req_ready, exp_gd);
            if (exp_gi || exp_gd) begin
                a = exp_gi ? i_req_addr : d_req_addr;
                f = is_fault(a);
                chk("mem_addr", mem_addr, a >> 2);
                chk("mem_we", mem_we, exp_gd && d_req_we && !f);
            end else begin
                chk("idle_mem_we", mem_we, 0);
                chk("idle_mem_addr", mem_addr, 0);
            end
            if (!i_req_valid || exp_gi) wait_cnt = 0;
            else if (i_el && exp_gd && wait_cnt < LIMIT) wait_cnt++;

            if (i_req_valid && i_req_ready) begin
                f = is_fault(i_req_addr);
                e.err   = f;
                e.rdata = f ? 32'h0 : ref_mem[i_req_addr[7:2]];
                iq.push_back(e);
            end
            if (d_req_valid && d_req_ready) begin
                f = is_fault(d_req_addr);
                e.err   = f;
                e.rdata = (f || d_req_we) ? 32'h0 : ref_mem[d_req_addr[7:2]];
                if (!f && d_req_we) ref_mem[d_req_addr[7:2]] = d_req_wdata;
                dq.push_back(e);
            end
        end
    end

    // Monitor: pop on each consumed response; check stability under backpressure.
    logic        hold_i = 1'b0, hold_d = 1'b0;
    logic [32:0] held_i, held_d;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (rst_prev) begin
                chk("rst_i_rsp_valid", i_rsp_valid, 0);
                chk("rst_d_rsp_valid", d_rsp_valid, 0);
            end
            iq.delete();
            dq.delete();
            hold_i = 1'b0;
            hold_d = 1'b0;
        end else begin
            if (hold_i) begin
                chk("i_stable_valid", i_rsp_valid, 1);
                chk("i_stable_data", {i_rsp_err, i_rsp_rdata}, held_i[31:0]);
            end
            if (hold_d) begin
                chk("d_stable_valid", d_rsp_valid, 1);
                chk("d_stable_data", {d_rsp_err, d_rsp_rdata}, held_d[31:0]);
            end
            hold_i = i_rsp_valid && !i_rsp_ready;
            hold_d = d_rsp_valid && !d_rsp_ready;
            held_i = {i_rsp_err, i_rsp_rdata};
            held_d = {d_rsp_err, d_rsp_rdata};
            if (i_rsp_valid && i_rsp_ready) begin
                if (iq.size() == 0) chk("i_unexpected_rsp", 1, 0);
                else begin
                    e = iq.pop_front();
                    chk("i_rsp_rdata", i_rsp_rdata, e.rdata);
                    chk("i_rsp_err", i_rsp_err, e.err);
                end
            end
            if (d_rsp_valid && d_rsp_ready) begin
                if (dq.size() == 0) chk("d_unexpected_rsp", 1, 0);
                else begin
                    e = dq.pop_front();
                    chk("d_rsp_rdata", d_rsp_rdata, e.rdata);
                    chk("d_rsp_err", d_rsp_err, e.err);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
        i_rsp_ready = 1'b1;
        d_rsp_ready = 1'b1;
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 15);
        if (r == 0) return {24'h0, 2'($urandom_range(0, 63)), 6'h0} | 32'($urandom_range(1, 3));
        if (r == 1) return 32'($urandom_range(WORDS, WORDS + 200)) << 2;
        if (r == 2) return 32'hFFFF_FFFC;
        return 32'($urandom_range(0, 15)) << 2;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic i_acc, d_acc;
        rst = 1'b1;
        i_req_valid = 1'b1; i_req_addr = 32'h0;
        d_req_valid = 1'b1; d_req_addr = 32'h4; d_req_we = 1'b0; d_req_wdata = 32'h0;
        i_rsp_ready = 1'b1; d_rsp_ready = 1'b1;

        // Reset with both requests pending; ready resumes right after.
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_d_ready", d_req_ready, 1);
        cyc(); idle();
        cyc();

        // Store then load the same word.
        d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 32'h08; d_req_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("store_mem_addr", mem_addr, 2);
        chk("store_mem_we", mem_we, 1);
        cyc();
        d_req_we = 1'b0;
        @(negedge clk);
        chk("load_ready", d_req_ready, 1);
        cyc(); idle();
        @(negedge clk);
        chk("load_rsp_rdata", d_rsp_rdata, 32'hDEAD_BEEF);
        chk("load_rsp_valid", d_rsp_valid, 1);

        // Misaligned and out-of-range stores must not write.
        cyc();
        d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 32'h06; d_req_wdata = 32'h1111_2222;
        @(negedge clk);
        chk("misalign_mem_we", mem_we, 0);
        cyc();
        d_req_addr = 32'h100;
        @(negedge clk);
        chk("oor_mem_we", mem_we, 0);
        chk("misalign_err", d_rsp_err, 1);
        cyc();
        d_req_we = 1'b0; d_req_addr = 32'h04;
        @(negedge clk);
        chk("oor_err", d_rsp_err, 1);
        cyc(); idle();
        cyc();

        // Starvation: D wins LIMIT cycles, then I gets one.
        i_req_valid = 1'b1; i_req_addr = 32'h10;
        d_req_valid = 1'b1; d_req_addr = 32'h14; d_req_we = 1'b0;
        for (int k = 0; k < 2 * (LIMIT + 1); k++) begin
            @(negedge clk);
            chk("starve_i_gnt", i_req_ready, (k % (LIMIT + 1)) == LIMIT);
        end
        cyc(); idle();
        cyc();

        // Backpressure on D: one D grant, then I every cycle.
        d_rsp_ready = 1'b0;
        i_req_valid = 1'b1; d_req_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("bp_d_ready", d_req_ready, k == 0);
            chk("bp_i_ready", i_req_ready, k != 0);
        end
        cyc(); idle();
        cyc();

        // Pass-through refill of the D slot.
        d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h08;
        cyc();
        d_req_addr = 32'h0C;
        @(negedge clk);
        chk("pt_ready", d_req_ready, 1);
        chk("pt_valid_before", d_rsp_valid, 1);
        cyc(); idle();
        @(negedge clk);
        chk("pt_valid_after", d_rsp_valid, 1);
        chk("pt_rdata", d_rsp_rdata, ref_mem[3]);
        cyc();

        // Random traffic with held requests and a reset in the middle.
        i_acc = 1'b0; d_acc = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            cyc();
            if (n == 1500) rst = 1'b1;
            if (n == 1502) rst = 1'b0;
            if (!(i_req_valid && !i_acc)) begin
                i_req_valid = ($urandom_range(0, 3) != 0);
                i_req_addr  = rand_addr();
            end
            if (!(d_req_valid && !d_acc)) begin
                d_req_valid = ($urandom_range(0, 3) != 0);
                d_req_addr  = rand_addr();
                d_req_we    = 1'($urandom_range(0, 1));
                d_req_wdata = $urandom();
            end
            if (n == 1500) begin
                d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 32'h20; d_req_wdata = 32'h5555_AAAA;
            end
            i_rsp_ready = ($urandom_range(0, 3) != 0);
            d_rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            i_acc = i_req_valid && i_req_ready;
            d_acc = d_req_valid && d_req_ready;
        end

        // Drain and confirm every issued request produced a response.
        cyc(); idle();
        repeat (3) cyc();
        chk("drain_iq_empty", iq.size(), 0);
        chk("drain_dq_empty", dq.size(), 0);
        for (int k = 0; k < WORDS; k++)
            chk("final_mem", mem[k], ref_mem[k]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
